uart_rx_byte_fifo: RTL and testbench

Downstream stage of the UART receive controller. It watches the receiver's Empty flag and copies each completed byte into a DEPTH-entry FIFO. It pulses Unload_data back to the receiver to release the byte, and presents the bytes to the bus side (the AXI-lite register block) through a first-word-fall-through pop interface. It also keeps sticky copies of the receiver's Overrun and Frame_error flags.

---
 rtl/uart_rx_byte_fifo.sv | 145 ++++++++++++++
 tb/tb_uart_rx_byte_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte_fifo.sv
// UART receive byte FIFO: copies completed bytes out of the receiver into a
// first-word-fall-through FIFO and keeps sticky copies of the receiver error flags.
module uart_rx_byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clock_50,
    input  logic              Resetn,
    input  logic [7:0]        RX_data,
    input  logic              RX_empty,
    input  logic              RX_overrun,
    input  logic              RX_frame_error,
    output logic              Unload_data,
    input  logic              Rd_en,
    output logic [7:0]        Rd_data,
    output logic              Fifo_empty,
    output logic              Fifo_full,
    output logic [ADDR_W:0]   Count,
    input  logic              Flush,
    input  logic              Clear_errors,
    output logic              Overrun_sticky,
    output logic              Frame_error_sticky
);

    localparam logic [1:0] S_CAP_IDLE  = 2'd0;
    localparam logic [1:0] S_CAP_PULSE = 2'd1;
    localparam logic [1:0] S_CAP_HOLD  = 2'd2;

    localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   C_DEPTH   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

    logic [1:0]        r_state;
    logic              r_unload;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_ovr_sticky;
    logic              r_fe_sticky;
    logic              r_fe_prev;
    logic [7:0]        r_mem [DEPTH];

    logic              w_wr;
    logic              w_pop;
    logic              w_fe_rise;
    logic [ADDR_W:0]   w_count_next;

    // Full is the registered pre-edge flag, so a same-cycle pop never frees a slot early.
    assign w_wr      = (r_state == S_CAP_IDLE) && !RX_empty && !r_full;
    assign w_pop     = Rd_en && !r_empty;
    assign w_fe_rise = RX_frame_error && !r_fe_prev;

    always_comb begin
        w_count_next = r_count;
        if (Flush)
            w_count_next = '0;
        else if (w_wr && !w_pop)
            w_count_next = r_count + C_CNT_ONE;
        else if (!w_wr && w_pop)
            w_count_next = r_count - C_CNT_ONE;
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= S_CAP_IDLE;
            r_unload <= 1'b0;
        end else begin
            case (r_state)
                S_CAP_IDLE: begin
                    if (w_wr) begin
                        r_state  <= S_CAP_PULSE;
                        r_unload <= 1'b1;
                    end
                end
                S_CAP_PULSE: begin
                    r_unload <= 1'b0;
                    r_state  <= S_CAP_HOLD;
                end
                S_CAP_HOLD: r_state <= S_CAP_IDLE;
                default: begin
                    r_state  <= S_CAP_IDLE;
                    r_unload <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (Flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr)
                    r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == C_DEPTH);
        end
    end

    // Storage is not reset; a flushed write lands in memory but the pointers hide it.
    always_ff @(posedge Clock_50) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= RX_data;
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_ovr_sticky <= 1'b0;
            r_fe_sticky  <= 1'b0;
            r_fe_prev    <= 1'b0;
        end else begin
            r_fe_prev <= RX_frame_error;
            if (w_wr && RX_overrun)
                r_ovr_sticky <= 1'b1;
            else if (Clear_errors)
                r_ovr_sticky <= 1'b0;
            if (w_fe_rise)
                r_fe_sticky <= 1'b1;
            else if (Clear_errors)
                r_fe_sticky <= 1'b0;
        end
    end

    assign Unload_data        = r_unload;
    assign Rd_data            = r_mem[r_rd_ptr];
    assign Fifo_empty         = r_empty;
    assign Fifo_full          = r_full;
    assign Count              = r_count;
    assign Overrun_sticky     = r_ovr_sticky;
    assign Frame_error_sticky = r_fe_sticky;

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// Scoreboard bench for uart_rx_byte_fifo with a behavioural receiver that
// releases one byte per Unload_data pulse.
module tb_uart_rx_byte_fifo;

    logic       Clock_50 = 1'b0;
    logic       Resetn = 1'b0;
    logic [7:0] RX_data = 8'h00;
    logic       RX_empty = 1'b1;
    logic       RX_overrun = 1'b0;
    logic       RX_frame_error = 1'b0;
    logic       Unload_data;
    logic       Rd_en = 1'b0;
    logic [7:0] Rd_data;
    logic       Fifo_empty;
    logic       Fifo_full;
    logic [4:0] Count;
    logic       Flush = 1'b0;
    logic       Clear_errors = 1'b0;
    logic       Overrun_sticky;
    logic       Frame_error_sticky;

    int n_cmp = 0;
    int n_err = 0;
    int n_unload = 0;
    logic [8:0] src_q[$];
    logic [7:0] exp_q[$];

    uart_rx_byte_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .Clock_50(Clock_50), .Resetn(Resetn), .RX_data(RX_data), .RX_empty(RX_empty),
        .RX_overrun(RX_overrun), .RX_frame_error(RX_frame_error), .Unload_data(Unload_data),
        .Rd_en(Rd_en), .Rd_data(Rd_data), .Fifo_empty(Fifo_empty), .Fifo_full(Fifo_full),
        .Count(Count), .Flush(Flush), .Clear_errors(Clear_errors),
        .Overrun_sticky(Overrun_sticky), .Frame_error_sticky(Frame_error_sticky)
    );

    always #10 Clock_50 = ~Clock_50;

    // Receiver: registered Empty, updated shortly after the edge that sees Unload_data.
    always begin
        logic [8:0] w;
        @(posedge Clock_50);
        #2;
        if (Unload_data) begin
            n_unload++;
            RX_empty   = 1'b1;
            RX_overrun = 1'b0;
        end
        if (RX_empty && src_q.size() > 0) begin
            w          = src_q.pop_front();
            RX_data    = w[7:0];
            RX_overrun = w[8];
            RX_empty   = 1'b0;
        end
    end

    task automatic push(input logic [7:0] d, input logic ovr);
        src_q.push_back({ovr, d});
        exp_q.push_back(d);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        n_cmp++;
        if (Fifo_empty !== 1'b0 || exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s pop: fifo_empty=%b expected entries=%0d", tag, Fifo_empty, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (Rd_data !== e) begin
                n_err++;
                $display("FAIL %s pop: got %h need %h", tag, Rd_data, e);
            end else
                $display("%s pop %h count=%0d", tag, Rd_data, Count);
            Rd_en = 1'b1;
            @(negedge Clock_50);
            Rd_en = 1'b0;
        end
    endtask

    task automatic wait_count(input logic [4:0] target, input int limit, input string tag);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge Clock_50);
            if (Count === target) break;
        end
        n_cmp++;
        if (i == limit) begin
            n_err++;
            $display("FAIL %s wait: count=%0d need %0d (timeout)", tag, Count, target);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({Unload_data, Count, Fifo_empty, Fifo_full, Overrun_sticky, Frame_error_sticky} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: unload=%b count=%0d empty=%b full=%b ovr=%b fe=%b need 0 0 1 0 0 0",
                     Unload_data, Count, Fifo_empty, Fifo_full, Overrun_sticky, Frame_error_sticky);
        end else $display("reset state ok");
    endtask

    task automatic test_single();
        int i;
        push(8'hA5, 1'b0);
        for (i = 1; i <= 10; i++) begin
            @(negedge Clock_50);
            if (Unload_data) break;
        end
        n_cmp++;
        if (i != 2) begin
            n_err++;
            $display("FAIL single latency: unload seen at cycle %0d need 2", i);
        end
        n_cmp++;
        if (Count !== 5'd1 || Fifo_empty !== 1'b0 || Rd_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single capture: count=%0d empty=%b data=%h need 1 0 a5", Count, Fifo_empty, Rd_data);
        end
        @(negedge Clock_50);
        n_cmp++;
        if (Unload_data !== 1'b0) begin
            n_err++;
            $display("FAIL single pulse width: unload=%b need 0", Unload_data);
        end
        pop_check("single");
        n_cmp++;
        if (Count !== 5'd0 || Fifo_empty !== 1'b1) begin
            n_err++;
            $display("FAIL single drain: count=%0d empty=%b need 0 1", Count, Fifo_empty);
        end
    endtask

    task automatic test_fill();
        int base = n_unload;
        for (int i = 0; i <= 16; i++) push(8'(i), 1'b0);
        wait_count(5'd16, 300, "fill");
        repeat (8) @(negedge Clock_50);
        n_cmp++;
        if (Fifo_full !== 1'b1 || Count !== 5'd16 || RX_empty !== 1'b0 || n_unload - base != 16) begin
            n_err++;
            $display("FAIL fill full: full=%b count=%0d rx_empty=%b unloads=%0d need 1 16 0 16",
                     Fifo_full, Count, RX_empty, n_unload - base);
        end
        pop_check("fill");
        wait_count(5'd16, 20, "fill refill");
        n_cmp++;
        if (n_unload - base != 17) begin
            n_err++;
            $display("FAIL fill 17th unload: unloads=%0d need 17", n_unload - base);
        end
        repeat (16) pop_check("fill");
        n_cmp++;
        if (Fifo_empty !== 1'b1 || Count !== 5'd0) begin
            n_err++;
            $display("FAIL fill drain: empty=%b count=%0d need 1 0", Fifo_empty, Count);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] max_cnt = '0;
        int j;
        for (int i = 0; i < 40; i++) begin
            push(8'(i), 1'b0);
            for (j = 0; j < 20; j++) begin
                @(negedge Clock_50);
                if (Count > max_cnt) max_cnt = Count;
                if (!Fifo_empty) break;
            end
            pop_check("wrap");
        end
        n_cmp++;
        if (max_cnt > 5'd2 || Count !== 5'd0) begin
            n_err++;
            $display("FAIL wrap: max count=%0d final count=%0d need <=2 and 0", max_cnt, Count);
        end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1'b0);
        wait_count(5'd5, 100, "simul");
        repeat (4) @(negedge Clock_50);
        push(8'h55, 1'b0);
        @(negedge Clock_50);
        // The pop lands on the same edge that captures 8'h55.
        pop_check("simul");
        n_cmp++;
        if (Unload_data !== 1'b1 || Count !== 5'd5 || Rd_data !== 8'h51) begin
            n_err++;
            $display("FAIL simul: unload=%b count=%0d head=%h need 1 5 51", Unload_data, Count, Rd_data);
        end
        repeat (5) pop_check("simul");
    endtask

    task automatic test_errors();
        push(8'h3C, 1'b1);
        wait_count(5'd1, 20, "overrun");
        n_cmp++;
        if (Overrun_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL overrun sticky: got %b need 1", Overrun_sticky);
        end
        pop_check("overrun");
        RX_frame_error = 1'b1;
        @(negedge Clock_50);
        n_cmp++;
        if (Frame_error_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL frame sticky: got %b need 1", Frame_error_sticky);
        end
        Clear_errors = 1'b1;
        @(negedge Clock_50);
        Clear_errors = 1'b0;
        n_cmp++;
        if (Overrun_sticky !== 1'b0 || Frame_error_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL clear errors: ovr=%b fe=%b need 0 0", Overrun_sticky, Frame_error_sticky);
        end
        RX_frame_error = 1'b0;
        @(negedge Clock_50);
        RX_frame_error = 1'b1;
        Clear_errors   = 1'b1;
        @(negedge Clock_50);
        Clear_errors   = 1'b0;
        RX_frame_error = 1'b0;
        n_cmp++;
        if (Frame_error_sticky !== 1'b1 || Overrun_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL set beats clear: fe=%b ovr=%b need 1 0", Frame_error_sticky, Overrun_sticky);
        end
        Clear_errors = 1'b1;
        @(negedge Clock_50);
        Clear_errors = 1'b0;
    endtask

    task automatic test_flush();
        int base = n_unload;
        for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i), 1'b0);
        wait_count(5'd3, 100, "flush");
        repeat (2) @(negedge Clock_50);
        Flush = 1'b1;
        @(negedge Clock_50);
        Flush = 1'b0;
        n_cmp++;
        if (Count !== 5'd0 || Fifo_empty !== 1'b1 || Unload_data !== 1'b1) begin
            n_err++;
            $display("FAIL flush: count=%0d empty=%b unload=%b need 0 1 1", Count, Fifo_empty, Unload_data);
        end
        @(negedge Clock_50);
        n_cmp++;
        if (Unload_data !== 1'b0 || n_unload - base != 4) begin
            n_err++;
            $display("FAIL flush unload: unload=%b unloads=%0d need 0 4", Unload_data, n_unload - base);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int i;
        push(8'h77, 1'b1);
        for (i = 0; i < 20; i++) begin
            @(negedge Clock_50);
            if (Unload_data) break;
        end
        n_cmp++;
        if (i == 20 || Overrun_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL reset-mid setup: unload timeout=%0d ovr=%b need 0 1", i == 20, Overrun_sticky);
        end
        #2 Resetn = 1'b0;
        #1;
        n_cmp++;
        if ({Unload_data, Count, Fifo_empty, Fifo_full, Overrun_sticky, Frame_error_sticky} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset-mid: unload=%b count=%0d empty=%b full=%b ovr=%b fe=%b need 0 0 1 0 0 0",
                     Unload_data, Count, Fifo_empty, Fifo_full, Overrun_sticky, Frame_error_sticky);
        end
        @(negedge Clock_50);
        Resetn = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge Clock_50);
        Resetn = 1'b1;
        @(negedge Clock_50);
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_simul();
        test_errors();
        test_flush();
        test_reset_mid();
        repeat (3) @(negedge Clock_50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
